// File: rtl/carpma_denetleyici.sv
// rtl/carpma_denetleyici.sv - sequencer between a request port and a multi-cycle 32x32 multiplier
// Optional last-product cache enabled by defining CARPMA_ONBELLEK_EN.
module carpma_denetleyici #(
    parameter int BEKLEME_SINIRI = 24
) (
    input  logic        clk,
    input  logic        rst_g,
    input  logic        istek_gecerli,
    output logic        hazir,
    input  logic [1:0]  islem,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        sonuc_gecerli,
    input  logic        sonuc_hazir,
    output logic [31:0] sonuc,
    output logic        hata,
    output logic [31:0] carpici_a,
    output logic [31:0] carpici_b,
    output logic        carpici_a_isaretli,
    output logic        carpici_b_isaretli,
    output logic        carpici_istek,
    input  logic [63:0] carpici_sonuc,
    input  logic        carpici_bitti
);

    localparam int SW = $clog2(BEKLEME_SINIRI + 1);
    localparam logic [SW-1:0] SAYAC_SON = SW'(BEKLEME_SINIRI - 1);

    typedef enum logic [1:0] {BOS, ISTEK, BEKLE, SONUC} durum_t;

    durum_t      durum;
    logic [SW-1:0] sayac;
    logic [1:0]  islem_r;
    logic        a_isaretli;
    logic        b_isaretli;
    logic        onb_isabet;
    logic [31:0] onb_sonuc;

    always_comb begin
        a_isaretli = (islem == 2'b01) || (islem == 2'b10);
        b_isaretli = (islem == 2'b01);
    end

`ifdef CARPMA_ONBELLEK_EN
    logic        onb_gecerli;
    logic [31:0] onb_rs1;
    logic [31:0] onb_rs2;
    logic        onb_as;
    logic        onb_bs;
    logic [63:0] onb_carpim;

    // The low half does not depend on signedness, so MUL only needs matching operands.
    always_comb begin
        onb_isabet = onb_gecerli && (rs1 == onb_rs1) && (rs2 == onb_rs2) &&
                     ((islem == 2'b00) || ((a_isaretli == onb_as) && (b_isaretli == onb_bs)));
        onb_sonuc  = (islem == 2'b00) ? onb_carpim[31:0] : onb_carpim[63:32];
    end
`else
    always_comb begin
        onb_isabet = 1'b0;
        onb_sonuc  = 32'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst_g) begin
        if (rst_g) begin
            durum              <= BOS;
            hazir              <= 1'b1;
            sonuc_gecerli      <= 1'b0;
            sonuc              <= 32'b0;
            hata               <= 1'b0;
            carpici_istek      <= 1'b0;
            carpici_a          <= 32'b0;
            carpici_b          <= 32'b0;
            carpici_a_isaretli <= 1'b0;
            carpici_b_isaretli <= 1'b0;
            sayac              <= '0;
            islem_r            <= 2'b00;
`ifdef CARPMA_ONBELLEK_EN
            onb_gecerli        <= 1'b0;
            onb_rs1            <= 32'b0;
            onb_rs2            <= 32'b0;
            onb_as             <= 1'b0;
            onb_bs             <= 1'b0;
            onb_carpim         <= 64'b0;
`endif
        end else begin
            carpici_istek <= 1'b0;
            case (durum)
                BOS: begin
                    if (istek_gecerli) begin
                        carpici_a          <= rs1;
                        carpici_b          <= rs2;
                        carpici_a_isaretli <= a_isaretli;
                        carpici_b_isaretli <= b_isaretli;
                        islem_r            <= islem;
                        hazir              <= 1'b0;
                        if (onb_isabet) begin
                            durum         <= SONUC;
                            sonuc         <= onb_sonuc;
                            hata          <= 1'b0;
                            sonuc_gecerli <= 1'b1;
                        end else begin
                            durum         <= ISTEK;
                            carpici_istek <= 1'b1;
                        end
                    end
                end
                ISTEK: begin
                    durum <= BEKLE;
                    sayac <= '0;
                end
                BEKLE: begin
                    // A done pulse on the limit cycle still delivers the real product.
                    if (carpici_bitti) begin
                        durum         <= SONUC;
                        sonuc         <= (islem_r == 2'b00) ? carpici_sonuc[31:0] : carpici_sonuc[63:32];
                        hata          <= 1'b0;
                        sonuc_gecerli <= 1'b1;
`ifdef CARPMA_ONBELLEK_EN
                        onb_gecerli   <= 1'b1;
                        onb_rs1       <= carpici_a;
                        onb_rs2       <= carpici_b;
                        onb_as        <= carpici_a_isaretli;
                        onb_bs        <= carpici_b_isaretli;
                        onb_carpim    <= carpici_sonuc;
`endif
                    end else if (sayac == SAYAC_SON) begin
                        durum         <= SONUC;
                        sonuc         <= 32'b0;
                        hata          <= 1'b1;
                        sonuc_gecerli <= 1'b1;
`ifdef CARPMA_ONBELLEK_EN
                        onb_gecerli   <= 1'b0;
`endif
                    end else begin
                        sayac <= sayac + 1'b1;
                    end
                end
                SONUC: begin
                    if (sonuc_hazir) begin
                        durum         <= BOS;
                        sonuc_gecerli <= 1'b0;
                        hata          <= 1'b0;
                        hazir         <= 1'b1;
                    end
                end
                default: durum <= BOS;
            endcase
        end
    end

endmodule

// File: tb/tb_carpma_denetleyici.sv
// tb/tb_carpma_denetleyici.sv - directed scoreboard bench for carpma_denetleyici
module tb_carpma_denetleyici;

    logic        clk = 1'b0;
    logic        rst_g = 1'b1;
    logic        istek_gecerli = 1'b0;
    logic        hazir;
    logic [1:0]  islem = 2'b00;
    logic [31:0] rs1 = 32'b0;
    logic [31:0] rs2 = 32'b0;
    logic        sonuc_gecerli;
    logic        sonuc_hazir = 1'b0;
    logic [31:0] sonuc;
    logic        hata;
    logic [31:0] carpici_a;
    logic [31:0] carpici_b;
    logic        carpici_a_isaretli;
    logic        carpici_b_isaretli;
    logic        carpici_istek;
    logic [63:0] carpici_sonuc;
    logic        carpici_bitti;

    int n_assert = 0;
    int n_fail = 0;
    logic [32:0] sb[$];

    // Multiplier model: product latched on the start pulse, done pulse lat+1 edges later.
    int          mul_lat = 17;
    bit          mul_off = 1'b0;
    int          m_cnt = 0;
    logic        m_bitti = 1'b0;
    logic        ek_bitti = 1'b0;
    logic [63:0] m_urun = 64'b0;
    logic signed [32:0] ma;
    logic signed [32:0] mb;
    logic signed [65:0] mp;
    int          istek_sayisi = 0;
    logic        sa_gor = 1'b0;
    logic        sb_gor = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        ma = $signed({carpici_a_isaretli & carpici_a[31], carpici_a});
        mb = $signed({carpici_b_isaretli & carpici_b[31], carpici_b});
        mp = ma * mb;
        carpici_sonuc = m_bitti ? m_urun : 64'hDEAD_BEEF_DEAD_BEEF;
        carpici_bitti = m_bitti | ek_bitti;
    end

    always @(posedge clk) begin
        if (carpici_istek) begin
            m_cnt  <= mul_lat;
            m_urun <= mp[63:0];
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
        m_bitti <= (m_cnt == 1) && !mul_off;
    end

    always @(negedge clk) begin
        if (carpici_istek) begin
            istek_sayisi <= istek_sayisi + 1;
            sa_gor       <= carpici_a_isaretli;
            sb_gor       <= carpici_b_isaretli;
        end
    end

    carpma_denetleyici #(.BEKLEME_SINIRI(24)) dut (
        .clk(clk), .rst_g(rst_g), .istek_gecerli(istek_gecerli), .hazir(hazir),
        .islem(islem), .rs1(rs1), .rs2(rs2), .sonuc_gecerli(sonuc_gecerli),
        .sonuc_hazir(sonuc_hazir), .sonuc(sonuc), .hata(hata),
        .carpici_a(carpici_a), .carpici_b(carpici_b),
        .carpici_a_isaretli(carpici_a_isaretli), .carpici_b_isaretli(carpici_b_isaretli),
        .carpici_istek(carpici_istek), .carpici_sonuc(carpici_sonuc),
        .carpici_bitti(carpici_bitti)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_sonuc(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sbv;
        longint ua;
        longint ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        case (op)
            2'b00:   p = ua * ub;
            2'b01:   p = sa * sbv;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // en: edges from the acceptance edge until sonuc_gecerli is seen; eist: start pulses expected.
    task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input bit off, input logic [31:0] es, input logic eh,
                           input int en, input int eist, input int hold);
        int n;
        int ist0;
        logic [32:0] e;
        sb.push_back({eh, es});
        mul_lat = lat;
        mul_off = off;
        @(negedge clk);
        chk("hazir_bos", hazir, 1);
        istek_gecerli = 1'b1;
        islem = op;
        rs1 = a;
        rs2 = b;
        ist0 = istek_sayisi;
        @(posedge clk);
        #1;
        istek_gecerli = 1'b0;
        rs1 = ~a;
        rs2 = ~b;
        islem = ~op;
        n = 0;
        while (!sonuc_gecerli && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("gecikme", n, en);
        e = sb.pop_front();
        chk("sonuc", sonuc, e[31:0]);
        chk("hata", hata, e[32]);
        if (eist != 0) begin
            chk("isaret_a", sa_gor, (op == 2'b01) || (op == 2'b10));
            chk("isaret_b", sb_gor, op == 2'b01);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            istek_gecerli = 1'b1;
            chk("tutma", {hazir, sonuc_gecerli, hata, sonuc}, {1'b0, 1'b1, e[32], e[31:0]});
        end
        @(negedge clk);
        istek_gecerli = 1'b0;
        sonuc_hazir = 1'b1;
        @(posedge clk);
        #1;
        sonuc_hazir = 1'b0;
        chk("birakma", {hazir, sonuc_gecerli}, 2'b10);
        chk("istek_darbe", istek_sayisi - ist0, eist);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          rl;
        int          seen;

        #3;
        chk("reset_cikis", {sonuc_gecerli, hata, carpici_istek, carpici_a_isaretli,
                            carpici_b_isaretli}, 5'b0);
        chk("reset_veri", {sonuc, carpici_a, carpici_b}, 96'b0);
        @(negedge clk);
        @(negedge clk);
        rst_g = 1'b0;
        @(negedge clk);
        chk("reset_hazir", hazir, 1);

        run_req(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17, 0, 32'hFFFF_FFFE, 0, 19, 1, 0);
        run_req(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 17, 0, 32'hFFFF_FFFA, 0, 19, 1, 0);
        run_req(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 17, 0, 32'hFFFF_FFFF, 0, 19, 1, 0);
        run_req(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17, 0, 32'hFFFF_FFFF, 0, 19, 1, 10);

        for (int k = 0; k < 4; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            rl  = $urandom_range(1, 22);
            run_req(rop, ra, rb, rl, 0, ref_sonuc(rop, ra, rb), 0, rl + 2, 1, 0);
        end

        run_req(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 17, 1, 32'h0, 1, 25, 1, 0);
        run_req(2'b11, 32'h8000_0000, 32'h0000_0004, 17, 0, 32'h0000_0002, 0, 19, 1, 0);
        run_req(2'b01, 32'h0001_0000, 32'hFFFF_0000, 23, 0, 32'hFFFF_FFFF, 0, 25, 1, 0);

        @(negedge clk);
        ek_bitti = 1'b1;
        @(posedge clk);
        #1;
        ek_bitti = 1'b0;
        chk("bos_bitti", {hazir, sonuc_gecerli}, 2'b10);

`ifdef CARPMA_ONBELLEK_EN
        run_req(2'b01, 32'd7, 32'd9, 17, 0, 32'd0, 0, 19, 1, 0);
        run_req(2'b00, 32'd7, 32'd9, 17, 0, 32'd63, 0, 0, 0, 0);
`else
        run_req(2'b00, 32'd5, 32'd6, 17, 0, 32'd30, 0, 19, 1, 0);
        run_req(2'b00, 32'd5, 32'd6, 17, 0, 32'd30, 0, 19, 1, 0);
`endif

        mul_lat = 17;
        mul_off = 1'b0;
        @(negedge clk);
        istek_gecerli = 1'b1;
        islem = 2'b11;
        rs1 = 32'd7;
        rs2 = 32'd9;
        @(posedge clk);
        #1;
        istek_gecerli = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_g = 1'b1;
        #1;
        chk("reset_orta", {sonuc_gecerli, hata, carpici_istek, hazir}, 4'b0001);
        chk("reset_orta_veri", {sonuc, carpici_a, carpici_b}, 96'b0);
        @(negedge clk);
        rst_g = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (sonuc_gecerli) seen++;
        end
        chk("gec_bitti", seen, 0);

        run_req(2'b00, 32'd7, 32'd9, 17, 0, 32'd63, 0, 19, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
